// File: rtl/crossbar_port_arbiter.sv
// ============================================================================
// Module      : crossbar_port_arbiter
// Description : Round-robin owner arbiter with per-grant timeout for one
//               crossbar output port; drives the registered {valid,index} select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] last,
  output logic [2:0] Answer,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout_evt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam bit               C_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           r_state;
  logic [1:0]       r_rr_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_next_state;
  logic [1:0]       w_next_rr_ptr;
  logic [CNT_W-1:0] w_next_cnt;
  logic [2:0]       w_next_answer;
  logic [3:0]       w_next_grant;
  logic             w_next_busy;
  logic             w_next_tevt;

  logic [1:0]       w_owner;
  logic             w_rel_a;
  logic             w_rel_b;
  logic             w_rel_c;
  logic             w_found;
  logic [1:0]       w_winner;
  logic [1:0]       w_idx;

  assign w_owner = Answer[1:0];
  assign w_rel_a = req[w_owner] & last[w_owner];
  assign w_rel_b = ~req[w_owner];
  // Timeout only fires when neither normal release condition applies.
  assign w_rel_c = C_TO_EN && (r_cnt == C_TO_LAST) && !w_rel_a && !w_rel_b;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_rr_ptr = r_rr_ptr;
    w_next_cnt    = r_cnt;
    w_next_answer = Answer;
    w_next_grant  = grant;
    w_next_busy   = busy;
    w_next_tevt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_answer = 3'b000;
        w_next_grant  = 4'b0000;
        w_next_busy   = 1'b0;
        w_next_cnt    = '0;
        if (w_found) begin
          w_next_state  = ST_GRANT;
          w_next_answer = {1'b1, w_winner};
          w_next_grant  = 4'b0001 << w_winner;
          w_next_busy   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_rel_a || w_rel_b || w_rel_c) begin
          w_next_state  = ST_IDLE;
          w_next_answer = 3'b000;
          w_next_grant  = 4'b0000;
          w_next_busy   = 1'b0;
          w_next_rr_ptr = w_owner;
          w_next_cnt    = '0;
          w_next_tevt   = w_rel_c;
        end else if (r_cnt != C_CNT_MAX) begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_next_answer = 3'b000;
        w_next_grant  = 4'b0000;
        w_next_busy   = 1'b0;
        w_next_cnt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd3;
      r_cnt       <= '0;
      Answer      <= 3'b000;
      grant       <= 4'b0000;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rr_ptr    <= w_next_rr_ptr;
      r_cnt       <= w_next_cnt;
      Answer      <= w_next_answer;
      grant       <= w_next_grant;
      busy        <= w_next_busy;
      timeout_evt <= w_next_tevt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crossbar_port_arbiter.sv
// ============================================================================
// Module      : tb_crossbar_port_arbiter
// Description : Scoreboard bench for crossbar_port_arbiter (default and 4-cycle timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crossbar_port_arbiter;

    typedef struct {
        bit         sel;
        logic [2:0] ans;
        logic       tevt;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req_a, last_a, req_b, last_b;
    logic [2:0] ans_a, ans_b;
    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b, tevt_a, tevt_b;

    exp_t       sb[$];
    exp_t       e;
    logic [8:0] act, expv;
    int         errors = 0;
    int         checks = 0;

    crossbar_port_arbiter dut_a (
        .clk(clk), .reset(reset), .req(req_a), .last(last_a),
        .Answer(ans_a), .grant(grant_a), .busy(busy_a), .timeout_evt(tevt_a)
    );

    crossbar_port_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .last(last_b),
        .Answer(ans_b), .grant(grant_b), .busy(busy_b), .timeout_evt(tevt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            act  = e.sel ? {ans_b, grant_b, busy_b, tevt_b} : {ans_a, grant_a, busy_a, tevt_a};
            expv = {e.ans, (e.ans[2] ? (4'b0001 << e.ans[1:0]) : 4'b0000), e.ans[2], e.tevt};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL %s (dut_%s): got Answer=%b grant=%b busy=%b tevt=%b, want Answer=%b grant=%b busy=%b tevt=%b",
                         e.name, e.sel ? "b" : "a", act[8:6], act[5:2], act[1], act[0],
                         expv[8:6], expv[5:2], expv[1], expv[0]);
            end
        end
    end

    task automatic check_now(input bit sel, input logic [2:0] ans, input logic tevt, input string name);
        logic [8:0] a_now;
        logic [8:0] x_now;
        a_now = sel ? {ans_b, grant_b, busy_b, tevt_b} : {ans_a, grant_a, busy_a, tevt_a};
        x_now = {ans, (ans[2] ? (4'b0001 << ans[1:0]) : 4'b0000), ans[2], tevt};
        checks++;
        if (a_now !== x_now) begin
            errors++;
            $display("FAIL %s (dut_%s, immediate): got Answer=%b grant=%b busy=%b tevt=%b, want Answer=%b grant=%b busy=%b tevt=%b",
                     name, sel ? "b" : "a", a_now[8:6], a_now[5:2], a_now[1], a_now[0],
                     x_now[8:6], x_now[5:2], x_now[1], x_now[0]);
        end
    endtask

    task automatic push(input bit sel, input logic [2:0] ans, input logic tevt, input string name);
        exp_t x;
        x.sel  = sel;
        x.ans  = ans;
        x.tevt = tevt;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic drive(input bit sel, input logic [3:0] r, input logic [3:0] l);
        req_a  = sel ? 4'b0 : r;
        last_a = sel ? 4'b0 : l;
        req_b  = sel ? r : 4'b0;
        last_b = sel ? l : 4'b0;
    endtask

    task automatic cyc(input bit sel, input logic [3:0] r, input logic [3:0] l,
                       input logic [2:0] ans, input logic tevt, input string name);
        drive(sel, r, l);
        @(posedge clk);
        #1;
        push(sel, ans, tevt, name);
    endtask

    task automatic reset_pulse(input string name);
        drive(1'b0, 4'b0, 4'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(1'b0, 3'b000, 1'b0, name);
        push(1'b1, 3'b000, 1'b0, name);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'b0, 4'b0);
        reset_pulse("reset_state");

        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b1111, 4'b1111, {1'b1, 2'(k)}, 1'b0, "rr_grant");
            cyc(1'b0, 4'b1111, 4'b0000, {1'b1, 2'(k)}, 1'b0, "rr_hold");
            cyc(1'b0, 4'b1111, 4'b1111, 3'b000,        1'b0, "rr_gap");
        end
        cyc(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, "rr_idle");

        for (int k = 0; k < 5; k++)
            cyc(1'b0, 4'b0100, 4'b0000, 3'b110, 1'b0, "single_hold");
        cyc(1'b0, 4'b0100, 4'b0100, 3'b000, 1'b0, "single_last");
        cyc(1'b0, 4'b0100, 4'b0000, 3'b110, 1'b0, "single_regrant");

        drive(1'b0, 4'b0100, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_now(1'b0, 3'b000, 1'b0, "mid_grant_reset_async");
        push(1'b0, 3'b000, 1'b0, "mid_grant_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 4'b0001, 4'b0000, 3'b100, 1'b0, "post_reset_grant");
        cyc(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, "post_reset_drop");

        cyc(1'b0, 4'b1010, 4'b0000, 3'b101, 1'b0, "wd_grant");
        cyc(1'b0, 4'b1010, 4'b0000, 3'b101, 1'b0, "wd_hold");
        cyc(1'b0, 4'b1010, 4'b0000, 3'b101, 1'b0, "wd_hold3");
        cyc(1'b0, 4'b1000, 4'b0000, 3'b000, 1'b0, "wd_release");
        cyc(1'b0, 4'b1000, 4'b0000, 3'b111, 1'b0, "wd_next_owner");
        cyc(1'b0, 4'b1000, 4'b1000, 3'b000, 1'b0, "wd_next_last");
        cyc(1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, "wd_idle");

        for (int k = 0; k < 4; k++)
            cyc(1'b1, 4'b0001, 4'b0000, 3'b100, 1'b0, "to_hold");
        cyc(1'b1, 4'b0001, 4'b0000, 3'b000, 1'b1, "to_release");
        check_now(1'b1, 3'b000, 1'b1, "to_release_evt");
        cyc(1'b1, 4'b0001, 4'b0000, 3'b100, 1'b0, "to_regrant");
        check_now(1'b1, 3'b100, 1'b0, "to_evt_cleared");
        cyc(1'b1, 4'b1001, 4'b1000, 3'b100, 1'b0, "nonowner_last");
        cyc(1'b1, 4'b1001, 4'b1000, 3'b100, 1'b0, "nonowner_last2");
        cyc(1'b1, 4'b1001, 4'b0000, 3'b100, 1'b0, "coin_hold4");
        cyc(1'b1, 4'b1001, 4'b0001, 3'b000, 1'b0, "coin_release");
        cyc(1'b1, 4'b1001, 4'b0000, 3'b111, 1'b0, "coin_next_owner");
        cyc(1'b1, 4'b0000, 4'b0000, 3'b000, 1'b0, "coin_withdraw");
        cyc(1'b1, 4'b0000, 4'b0000, 3'b000, 1'b0, "coin_idle");

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
